// File: rtl/warp_fetch_sched_pkg.sv
// Shared GPU scheduler definitions: warp count, lane geometry and the per-warp state encoding.
package warp_fetch_sched_pkg;

  localparam int unsigned NUM_WARPS  = 8;
  localparam int unsigned LANE_WARPS = NUM_WARPS / 2;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StReady  = 3'd1,
    StPend   = 3'd2,
    StWaitBr = 3'd3,
    StDone   = 3'd4
  } warp_state_e;

endpackage

// File: rtl/warp_fetch_sched_if.sv
// Bundle of launch, decode-feedback, resolve and fetch-grant signals around the warp scheduler.
interface warp_fetch_sched_if;
  import warp_fetch_sched_pkg::*;

  logic                 Launch_en;
  logic [NUM_WARPS-1:0] Launch_mask;
  logic                 Stall_IF;
  logic [NUM_WARPS-1:0] IB_Full;
  logic [NUM_WARPS-1:0] Valid_ID0;
  logic [NUM_WARPS-1:0] Valid_ID1;
  logic                 Ctrl_ID0;
  logic                 Ctrl_ID1;
  logic                 Exit_ID0;
  logic                 Exit_ID1;
  logic [NUM_WARPS-1:0] Resolve;
  logic [NUM_WARPS-1:0] Valid_IF0;
  logic [NUM_WARPS-1:0] Valid_IF1;
  logic [NUM_WARPS-1:0] Active;
  logic                 All_Done;
  logic [31:0]          Fetch_Count;

  modport master (
    output Launch_en, Launch_mask, Stall_IF, IB_Full, Valid_ID0, Valid_ID1,
           Ctrl_ID0, Ctrl_ID1, Exit_ID0, Exit_ID1, Resolve,
    input  Valid_IF0, Valid_IF1, Active, All_Done, Fetch_Count
  );

  modport slave (
    input  Launch_en, Launch_mask, Stall_IF, IB_Full, Valid_ID0, Valid_ID1,
           Ctrl_ID0, Ctrl_ID1, Exit_ID0, Exit_ID1, Resolve,
    output Valid_IF0, Valid_IF1, Active, All_Done, Fetch_Count
  );

endinterface

// File: rtl/warp_fetch_sched_rr_arb4.sv
// Four-requester round-robin arbiter; the search starts at ptr_q and ptr_q moves past each winner.
module rr_arb4 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt
);

  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx;
  logic [1:0] win_idx;
  logic       found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    gnt     = 4'b0000;
    found   = 1'b0;
    win_idx = ptr_q;
    idx     = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        win_idx  = idx;
        found    = 1'b1;
      end
    end
    ptr_d = found ? win_idx + 2'd1 : ptr_q;
  end

endmodule

// File: rtl/warp_fetch_sched.sv
// Two-lane warp fetch scheduler: lane 0 arbitrates warps 0-3, lane 1 warps 4-7, one grant each.
module warp_fetch_sched
  import warp_fetch_sched_pkg::*;
#(
  parameter int unsigned NUM_WARPS = warp_fetch_sched_pkg::NUM_WARPS
) (
  input  logic                     clk,
  input  logic                     rst,
  warp_fetch_sched_if.slave        bus
);

  warp_state_e          state_q [NUM_WARPS];
  warp_state_e          state_d [NUM_WARPS];
  logic [NUM_WARPS-1:0] launched_q, launched_d;
  logic [31:0]          fetch_count_q, fetch_count_d;
  logic [NUM_WARPS-1:0] elig;
  logic [NUM_WARPS-1:0] gnt_all;
  logic [NUM_WARPS-1:0] done_mask;
  logic [LANE_WARPS-1:0] gnt0, gnt1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < NUM_WARPS; w++) state_q[w] <= StIdle;
      launched_q    <= '0;
      fetch_count_q <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) state_q[w] <= state_d[w];
      launched_q    <= launched_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    elig = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      elig[w] = (state_q[w] == StReady) && !bus.IB_Full[w] && !bus.Stall_IF;
    end
  end

  rr_arb4 u_arb_lane0 (
    .clk (clk),
    .rst (rst),
    .req (elig[LANE_WARPS-1:0]),
    .gnt (gnt0)
  );

  rr_arb4 u_arb_lane1 (
    .clk (clk),
    .rst (rst),
    .req (elig[NUM_WARPS-1:LANE_WARPS]),
    .gnt (gnt1)
  );

  assign gnt_all = {gnt1, gnt0};

  // Next-state: decode lane 0 takes precedence if a warp somehow shows in both lanes
  always_comb begin
    launched_d    = launched_q;
    fetch_count_d = fetch_count_q + 32'(|gnt0) + 32'(|gnt1);
    for (int w = 0; w < NUM_WARPS; w++) begin
      state_d[w] = state_q[w];
      case (state_q[w])
        StIdle: begin
          if (bus.Launch_en && bus.Launch_mask[w]) begin
            state_d[w]    = StReady;
            launched_d[w] = 1'b1;
          end
        end
        StReady: begin
          if (gnt_all[w]) state_d[w] = StPend;
        end
        StPend: begin
          if (bus.Valid_ID0[w]) begin
            if (bus.Exit_ID0)      state_d[w] = StDone;
            else if (bus.Ctrl_ID0) state_d[w] = StWaitBr;
            else                   state_d[w] = StReady;
          end else if (bus.Valid_ID1[w]) begin
            if (bus.Exit_ID1)      state_d[w] = StDone;
            else if (bus.Ctrl_ID1) state_d[w] = StWaitBr;
            else                   state_d[w] = StReady;
          end
        end
        StWaitBr: begin
          if (bus.Resolve[w]) state_d[w] = StReady;
        end
        StDone:  state_d[w] = StDone;
        default: state_d[w] = StIdle;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.Active = '0;
    done_mask  = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      bus.Active[w] = (state_q[w] == StReady) || (state_q[w] == StPend) ||
                      (state_q[w] == StWaitBr);
      done_mask[w]  = (state_q[w] == StDone);
    end
    bus.All_Done    = (|launched_q) && ((launched_q & ~done_mask) == '0);
    bus.Valid_IF0   = {{LANE_WARPS{1'b0}}, gnt0};
    bus.Valid_IF1   = {gnt1, {LANE_WARPS{1'b0}}};
    bus.Fetch_Count = fetch_count_q;
  end

endmodule

// File: tb/tb_warp_fetch_sched.sv
// Directed bench for warp_fetch_sched with hand-computed grant, Active and count expectations.
module tb_warp_fetch_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  warp_fetch_sched_if bus ();

  warp_fetch_sched #(.NUM_WARPS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.Launch_en   = 1'b0;
    bus.Launch_mask = 8'h00;
    bus.Stall_IF    = 1'b0;
    bus.IB_Full     = 8'h00;
    bus.Valid_ID0   = 8'h00;
    bus.Valid_ID1   = 8'h00;
    bus.Ctrl_ID0    = 1'b0;
    bus.Ctrl_ID1    = 1'b0;
    bus.Exit_ID0    = 1'b0;
    bus.Exit_ID1    = 1'b0;
    bus.Resolve     = 8'h00;
  endtask

  // Asserted away from the clock edge; outputs must clear before any edge arrives.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    clear_inputs();
    #1;
    chk({tag, "_if0"}, 32'(bus.Valid_IF0), 32'h0);
    chk({tag, "_if1"}, 32'(bus.Valid_IF1), 32'h0);
    chk({tag, "_act"}, 32'(bus.Active), 32'h0);
    chk({tag, "_done"}, 32'(bus.All_Done), 32'h0);
    chk({tag, "_cnt"}, bus.Fetch_Count, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic launch(input string tag, input logic [7:0] mask);
    clear_inputs();
    bus.Launch_en   = 1'b1;
    bus.Launch_mask = mask;
    #2;
    chk({tag, "_if0"}, 32'(bus.Valid_IF0), 32'h0);
    chk({tag, "_if1"}, 32'(bus.Valid_IF1), 32'h0);
    @(posedge clk);
    #1;
    bus.Launch_en = 1'b0;
  endtask

  // flags = {Exit_ID1, Exit_ID0, Ctrl_ID1, Ctrl_ID0}
  task automatic step(input string tag, input logic stall, input logic [7:0] ibf,
                      input logic [7:0] id0, input logic [7:0] id1, input logic [3:0] flags,
                      input logic [7:0] res, input logic [7:0] e0, input logic [7:0] e1,
                      input logic [7:0] eact, input logic [31:0] ecnt);
    bus.Launch_en = 1'b0;
    bus.Stall_IF  = stall;
    bus.IB_Full   = ibf;
    bus.Valid_ID0 = id0;
    bus.Valid_ID1 = id1;
    bus.Ctrl_ID0  = flags[0];
    bus.Ctrl_ID1  = flags[1];
    bus.Exit_ID0  = flags[2];
    bus.Exit_ID1  = flags[3];
    bus.Resolve   = res;
    #2;
    chk({tag, "_if0"}, 32'(bus.Valid_IF0), 32'(e0));
    chk({tag, "_if1"}, 32'(bus.Valid_IF1), 32'(e1));
    chk({tag, "_act"}, 32'(bus.Active), 32'(eact));
    chk({tag, "_cnt"}, bus.Fetch_Count, ecnt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();

    // Round-robin rotation with decode echoing last cycle's grants
    do_reset("r1");
    launch("l1", 8'hFF);
    step("a0", 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 8'h01, 8'h10, 8'hFF, 0);
    step("a1", 0, 8'h00, 8'h01, 8'h10, 4'h0, 8'h00, 8'h02, 8'h20, 8'hFF, 2);
    step("a2", 0, 8'h00, 8'h02, 8'h20, 4'h0, 8'h00, 8'h04, 8'h40, 8'hFF, 4);
    step("a3", 0, 8'h00, 8'h04, 8'h40, 4'h0, 8'h00, 8'h08, 8'h80, 8'hFF, 6);
    step("a4", 0, 8'h00, 8'h08, 8'h80, 4'h0, 8'h00, 8'h01, 8'h10, 8'hFF, 8);

    // Warp 2 decodes a branch, is skipped until Resolve[2]
    do_reset("r2");
    launch("l2", 8'hFF);
    step("b0", 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 8'h01, 8'h10, 8'hFF, 0);
    step("b1", 0, 8'h00, 8'h01, 8'h10, 4'h0, 8'h00, 8'h02, 8'h20, 8'hFF, 2);
    step("b2", 0, 8'h00, 8'h02, 8'h20, 4'h0, 8'h00, 8'h04, 8'h40, 8'hFF, 4);
    step("b3", 0, 8'h00, 8'h04, 8'h40, 4'h1, 8'h00, 8'h08, 8'h80, 8'hFF, 6);
    step("b4", 0, 8'h00, 8'h08, 8'h80, 4'h0, 8'h00, 8'h01, 8'h10, 8'hFF, 8);
    step("b5", 0, 8'h00, 8'h01, 8'h10, 4'h0, 8'h00, 8'h02, 8'h20, 8'hFF, 10);
    step("b6", 0, 8'h00, 8'h02, 8'h20, 4'h0, 8'h04, 8'h08, 8'h40, 8'hFF, 12);
    step("b7", 0, 8'h00, 8'h08, 8'h40, 4'h0, 8'h00, 8'h01, 8'h80, 8'hFF, 14);
    step("b8", 0, 8'h00, 8'h01, 8'h80, 4'h0, 8'h00, 8'h02, 8'h10, 8'hFF, 16);
    step("b9", 0, 8'h00, 8'h02, 8'h10, 4'h0, 8'h00, 8'h04, 8'h20, 8'hFF, 18);

    // IB_Full on warp 4 only blocks lane 1's warp 4
    do_reset("r3");
    launch("l3", 8'hFF);
    step("c0", 0, 8'h10, 8'h00, 8'h00, 4'h0, 8'h00, 8'h01, 8'h20, 8'hFF, 0);
    step("c1", 0, 8'h10, 8'h01, 8'h20, 4'h0, 8'h00, 8'h02, 8'h40, 8'hFF, 2);
    step("c2", 0, 8'h10, 8'h02, 8'h40, 4'h0, 8'h00, 8'h04, 8'h80, 8'hFF, 4);
    step("c3", 0, 8'h10, 8'h04, 8'h80, 4'h0, 8'h00, 8'h08, 8'h20, 8'hFF, 6);
    step("c4", 0, 8'h10, 8'h08, 8'h20, 4'h0, 8'h00, 8'h01, 8'h40, 8'hFF, 8);

    // Global stall freezes grants, pointers and count; PEND warps stay PEND
    do_reset("r4");
    launch("l4", 8'hFF);
    step("d0", 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 8'h01, 8'h10, 8'hFF, 0);
    step("d1", 1, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 8'h00, 8'hFF, 2);
    step("d2", 1, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 8'h00, 8'hFF, 2);
    step("d3", 1, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 8'h00, 8'hFF, 2);
    step("d4", 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 8'h02, 8'h20, 8'hFF, 2);
    step("d5", 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 8'h04, 8'h40, 8'hFF, 4);
    step("d6", 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 8'h08, 8'h80, 8'hFF, 6);
    step("d7", 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 8'h00, 8'hFF, 8);

    // Warps 0 and 7 exit; DONE is terminal and relaunch is ignored
    do_reset("r5");
    launch("l5", 8'h81);
    step("e0", 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 8'h01, 8'h80, 8'h81, 0);
    chk("e0_done", 32'(bus.All_Done), 32'h0);
    step("e1", 0, 8'h00, 8'h01, 8'h80, 4'hC, 8'h00, 8'h00, 8'h00, 8'h81, 2);
    chk("e1_act", 32'(bus.Active), 32'h0);
    chk("e1_done", 32'(bus.All_Done), 32'h1);
    launch("l5b", 8'h01);
    chk("e2_act", 32'(bus.Active), 32'h0);
    chk("e2_done", 32'(bus.All_Done), 32'h1);
    step("e3", 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 2);

    // Mid-run reset with warps in PEND and WAIT_BR
    do_reset("r6");
    launch("l6", 8'hFF);
    step("f0", 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 8'h01, 8'h10, 8'hFF, 0);
    step("f1", 0, 8'h00, 8'h01, 8'h10, 4'h1, 8'h00, 8'h02, 8'h20, 8'hFF, 2);
    do_reset("r6m");
    step("f2", 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    step("f3", 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h01, 8'h00, 8'h00, 8'h00, 0);
    launch("l6b", 8'hFF);
    step("f4", 0, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 8'h01, 8'h10, 8'hFF, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
